// File: rtl/present_pkg.sv
// present_pkg: shared types and constants for the falling present
// and the bitmap stage that draws it.
package present_pkg;

    localparam int FRAC_BITS = 6;
    localparam int POS_W     = 11;
    localparam int SPEED_W   = 11;
    localparam int TIMER_W   = 16;

    localparam int DEFAULT_WIDTH_X  = 26;
    localparam int DEFAULT_HEIGHT_Y = 26;

    typedef enum logic [1:0] {
        IDLE,
        FALLING,
        LANDED,
        BLINKING
    } present_state_t;

    // Add one gravity step to a speed and clip it at the cap.
    function automatic logic [SPEED_W-1:0] next_speed(
        input logic [SPEED_W-1:0] spd,
        input logic [SPEED_W-1:0] grav,
        input logic [SPEED_W-1:0] cap
    );
        logic [SPEED_W:0] sum;
        sum = {1'b0, spd} + {1'b0, grav};
        if (sum > {1'b0, cap}) begin
            next_speed = cap;
        end else begin
            next_speed = sum[SPEED_W-1:0];
        end
    endfunction

endpackage

// File: rtl/present_rect.sv
// present_rect: box hit test and pixel offset for a square object
// anchored at its top-left corner.
module present_rect
    import present_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH_X,
    parameter int HEIGHT = DEFAULT_HEIGHT_Y
) (
    input  logic [POS_W-1:0] i_pixel_x,
    input  logic [POS_W-1:0] i_pixel_y,
    input  logic [POS_W-1:0] i_top_left_x,
    input  logic [POS_W-1:0] i_top_left_y,
    output logic [POS_W-1:0] o_offset_x,
    output logic [POS_W-1:0] o_offset_y,
    output logic             o_inside
);

    localparam int EXT_W = POS_W + 1;

    logic [EXT_W-1:0] w_right;
    logic [EXT_W-1:0] w_bottom;
    logic             w_in_x;
    logic             w_in_y;

    // One extra bit so a box near the right/bottom edge cannot wrap.
    always_comb begin
        o_offset_x = i_pixel_x - i_top_left_x;
        o_offset_y = i_pixel_y - i_top_left_y;
        w_right    = {1'b0, i_top_left_x} + EXT_W'(WIDTH);
        w_bottom   = {1'b0, i_top_left_y} + EXT_W'(HEIGHT);
        w_in_x     = (i_pixel_x >= i_top_left_x) &&
                     ({1'b0, i_pixel_x} < w_right);
        w_in_y     = (i_pixel_y >= i_top_left_y) &&
                     ({1'b0, i_pixel_y} < w_bottom);
        o_inside   = w_in_x && w_in_y;
    end

endmodule

// File: rtl/present_mover.sv
// present_mover: spawns a present, drops it under gravity, rests it on
// the floor, blinks it out, and removes it early when collected.
module present_mover
    import present_pkg::*;
#(
    parameter int OBJECT_WIDTH_X  = DEFAULT_WIDTH_X,
    parameter int OBJECT_HEIGHT_Y = DEFAULT_HEIGHT_Y,
    parameter int FLOOR_Y         = 440,
    parameter int GRAVITY         = 8,
    parameter int MAX_SPEED       = 384,
    parameter int LAND_FRAMES     = 300,
    parameter int BLINK_FRAMES    = 120,
    parameter int BLINK_SHIFT     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startOfFrame,
    input  logic             spawn,
    input  logic [POS_W-1:0] spawnX,
    input  logic [POS_W-1:0] spawnY,
    input  logic             collected,
    input  logic [POS_W-1:0] pixelX,
    input  logic [POS_W-1:0] pixelY,
    output logic [POS_W-1:0] offsetX,
    output logic [POS_W-1:0] offsetY,
    output logic             InsideRectangle,
    output logic             visible,
    output logic             active,
    output logic             presentTaken
);

    localparam int Y_W   = POS_W + FRAC_BITS;
    localparam int BOT_W = POS_W + 2;

    localparam logic [SPEED_W-1:0] GRAV_C  = SPEED_W'(GRAVITY);
    localparam logic [SPEED_W-1:0] CAP_C   = SPEED_W'(MAX_SPEED);
    localparam logic [BOT_W-1:0]   FLOOR_C = BOT_W'(FLOOR_Y);
    localparam logic [BOT_W-1:0]   H_C     = BOT_W'(OBJECT_HEIGHT_Y);
    localparam logic [TIMER_W-1:0] LAND_C  = TIMER_W'(LAND_FRAMES);
    localparam logic [TIMER_W-1:0] BLINK_C = TIMER_W'(BLINK_FRAMES);
    localparam logic [TIMER_W-1:0] ONE_C   = TIMER_W'(1);
    localparam logic [Y_W-1:0]     REST_Y  =
        Y_W'((FLOOR_Y - OBJECT_HEIGHT_Y) * (2 ** FRAC_BITS));

    present_state_t     r_state;
    present_state_t     w_state_nxt;
    logic [POS_W-1:0]   r_x;
    logic [POS_W-1:0]   w_x_nxt;
    logic [Y_W-1:0]     r_y;
    logic [Y_W-1:0]     w_y_nxt;
    logic [SPEED_W-1:0] r_speed;
    logic [SPEED_W-1:0] w_speed_nxt;
    logic [TIMER_W-1:0] r_timer;
    logic [TIMER_W-1:0] w_timer_nxt;
    logic               r_taken;
    logic               w_taken_nxt;

    logic [SPEED_W-1:0] w_fall_speed;
    logic [Y_W:0]       w_fall_y;
    logic [BOT_W-1:0]   w_fall_bottom;
    logic               w_floor_hit;
    logic [POS_W-1:0]   w_top_y;
    logic               w_inside;

    // One gravity step: new speed, new Y, and whether the box touches the floor.
    always_comb begin
        w_fall_speed  = next_speed(r_speed, GRAV_C, CAP_C);
        w_fall_y      = {1'b0, r_y} +
                        {{(Y_W + 1 - SPEED_W){1'b0}}, w_fall_speed};
        w_fall_bottom = {1'b0, w_fall_y[Y_W:FRAC_BITS]} + H_C;
        w_floor_hit   = (w_fall_bottom >= FLOOR_C);
    end

    // Next-state logic; collection outranks any frame update.
    always_comb begin
        w_state_nxt = r_state;
        w_x_nxt     = r_x;
        w_y_nxt     = r_y;
        w_speed_nxt = r_speed;
        w_timer_nxt = r_timer;
        w_taken_nxt = 1'b0;
        if (r_state == IDLE) begin
            if (spawn) begin
                w_state_nxt = FALLING;
                w_x_nxt     = spawnX;
                w_y_nxt     = {spawnY, {FRAC_BITS{1'b0}}};
                w_speed_nxt = '0;
                w_timer_nxt = '0;
            end
        end else if (collected) begin
            w_state_nxt = IDLE;
            w_taken_nxt = 1'b1;
            w_speed_nxt = '0;
            w_timer_nxt = '0;
        end else if (startOfFrame) begin
            unique case (r_state)
                FALLING: begin
                    if (w_floor_hit) begin
                        w_state_nxt = LANDED;
                        w_y_nxt     = REST_Y;
                        w_speed_nxt = '0;
                        w_timer_nxt = LAND_C;
                    end else begin
                        w_y_nxt     = w_fall_y[Y_W-1:0];
                        w_speed_nxt = w_fall_speed;
                    end
                end
                LANDED: begin
                    if (r_timer <= ONE_C) begin
                        w_state_nxt = BLINKING;
                        w_timer_nxt = BLINK_C;
                    end else begin
                        w_timer_nxt = r_timer - ONE_C;
                    end
                end
                BLINKING: begin
                    if (r_timer <= ONE_C) begin
                        w_state_nxt = IDLE;
                        w_timer_nxt = '0;
                    end else begin
                        w_timer_nxt = r_timer - ONE_C;
                    end
                end
                default: begin
                    w_state_nxt = IDLE;
                end
            endcase
        end
    end

    // State and motion registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_x     <= '0;
            r_y     <= '0;
            r_speed <= '0;
            r_timer <= '0;
            r_taken <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_x     <= w_x_nxt;
            r_y     <= w_y_nxt;
            r_speed <= w_speed_nxt;
            r_timer <= w_timer_nxt;
            r_taken <= w_taken_nxt;
        end
    end

    // Visibility: solid while falling or resting, gated by a timer bit while blinking.
    always_comb begin
        visible = 1'b0;
        active  = (r_state != IDLE);
        unique case (r_state)
            IDLE:     visible = 1'b0;
            FALLING:  visible = 1'b1;
            LANDED:   visible = 1'b1;
            BLINKING: visible = ~r_timer[BLINK_SHIFT];
            default:  visible = 1'b0;
        endcase
    end

    assign w_top_y = r_y[Y_W-1:FRAC_BITS];

    present_rect #(
        .WIDTH  (OBJECT_WIDTH_X),
        .HEIGHT (OBJECT_HEIGHT_Y)
    ) u_rect (
        .i_pixel_x    (pixelX),
        .i_pixel_y    (pixelY),
        .i_top_left_x (r_x),
        .i_top_left_y (w_top_y),
        .o_offset_x   (offsetX),
        .o_offset_y   (offsetY),
        .o_inside     (w_inside)
    );

    assign InsideRectangle = w_inside & active;
    assign presentTaken    = r_taken;

endmodule

// File: tb/tb_present_mover.sv
// tb_present_mover: directed and randomized checks of present_mover
// against a frame-level model of the present's life cycle.
module tb_present_mover;

    localparam int W      = 26;
    localparam int H      = 26;
    localparam int FLOOR  = 440;
    localparam int GRAV   = 8;
    localparam int MAXS   = 384;
    localparam int LANDF  = 4;
    localparam int BLINKF = 16;
    localparam int BSH    = 2;

    localparam int P_IDLE  = 0;
    localparam int P_FALL  = 1;
    localparam int P_LAND  = 2;
    localparam int P_BLINK = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        startOfFrame = 1'b0;
    logic        spawn = 1'b0;
    logic        collected = 1'b0;
    logic [10:0] spawnX = '0;
    logic [10:0] spawnY = '0;
    logic [10:0] pixelX = '0;
    logic [10:0] pixelY = '0;
    logic [10:0] offsetX;
    logic [10:0] offsetY;
    logic        InsideRectangle;
    logic        visible;
    logic        active;
    logic        presentTaken;

    int n_cmp = 0;
    int n_err = 0;
    int n_pulses = 0;

    int m_phase;
    int m_x;
    int m_y64;
    int m_spd;
    int m_timer;

    always #10 clk = ~clk;

    present_mover #(
        .LAND_FRAMES  (LANDF),
        .BLINK_FRAMES (BLINKF),
        .BLINK_SHIFT  (BSH)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .startOfFrame    (startOfFrame),
        .spawn           (spawn),
        .spawnX          (spawnX),
        .spawnY          (spawnY),
        .collected       (collected),
        .pixelX          (pixelX),
        .pixelY          (pixelY),
        .offsetX         (offsetX),
        .offsetY         (offsetY),
        .InsideRectangle (InsideRectangle),
        .visible         (visible),
        .active          (active),
        .presentTaken    (presentTaken)
    );

    initial begin
        #5000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE;
        m_x     = 0;
        m_y64   = 0;
        m_spd   = 0;
        m_timer = 0;
    endtask

    // One video frame of the present's life, in 1/64 px units.
    task automatic model_frame();
        case (m_phase)
            P_FALL: begin
                m_spd = (m_spd + GRAV > MAXS) ? MAXS : m_spd + GRAV;
                m_y64 = m_y64 + m_spd;
                if ((m_y64 / 64) + H >= FLOOR) begin
                    m_y64   = (FLOOR - H) * 64;
                    m_spd   = 0;
                    m_timer = LANDF;
                    m_phase = P_LAND;
                end
            end
            P_LAND: begin
                if (m_timer == 1) begin
                    m_timer = BLINKF;
                    m_phase = P_BLINK;
                end else begin
                    m_timer = m_timer - 1;
                end
            end
            P_BLINK: begin
                m_timer = m_timer - 1;
                if (m_timer == 0) m_phase = P_IDLE;
            end
            default: ;
        endcase
    endtask

    task automatic model_edge(input logic sof, input logic spw,
                              input int sx, input int sy,
                              input logic col, output int taken);
        taken = 0;
        if (m_phase == P_IDLE) begin
            if (spw) begin
                m_phase = P_FALL;
                m_x     = sx;
                m_y64   = sy * 64;
                m_spd   = 0;
                m_timer = 0;
            end
        end else if (col) begin
            m_phase = P_IDLE;
            taken   = 1;
        end else if (sof) begin
            model_frame();
        end
    endtask

    // Random pixel near the box; checks offsets, hit test and flags.
    task automatic check_all(input string tag);
        int ty;
        int r;
        int px;
        int py;
        logic exp_in;
        logic exp_vis;
        ty = m_y64 / 64;
        r  = int'($urandom_range(0, 59));
        px = (m_x + r - 17) & 2047;
        r  = int'($urandom_range(0, 59));
        py = (ty + r - 17) & 2047;
        pixelX = 11'(px);
        pixelY = 11'(py);
        #1;
        exp_in = (m_phase != P_IDLE) && (px >= m_x) && (px < m_x + W) &&
                 (py >= ty) && (py < ty + H);
        case (m_phase)
            P_IDLE:  exp_vis = 1'b0;
            P_BLINK: exp_vis = (((m_timer >> BSH) & 1) == 0);
            default: exp_vis = 1'b1;
        endcase
        chk({tag, ".offX"}, offsetX, (px - m_x) & 2047);
        chk({tag, ".offY"}, offsetY, (py - ty) & 2047);
        chk({tag, ".inside"}, InsideRectangle, exp_in);
        chk({tag, ".visible"}, visible, exp_vis);
        chk({tag, ".active"}, active, m_phase != P_IDLE);
    endtask

    task automatic step(input logic sof, input logic spw, input int sx,
                        input int sy, input logic col, input string tag);
        int exp_taken;
        startOfFrame = sof;
        spawn        = spw;
        spawnX       = 11'(sx);
        spawnY       = 11'(sy);
        collected    = col;
        @(posedge clk);
        #2;
        model_edge(sof, spw, sx, sy, col, exp_taken);
        chk({tag, ".taken"}, presentTaken, exp_taken);
        if (presentTaken === 1'b1) n_pulses++;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic frame(input string tag);
        step(1'b1, 1'b0, 0, 0, 1'b0, tag);
        step(1'b0, 1'b0, 0, 0, 1'b0, tag);
    endtask

    task automatic probe_y(output int y);
        pixelY = 11'(2047);
        #1;
        y = 2047 - int'(offsetY);
    endtask

    task automatic pix(input string tag, input int px, input int py,
                       input logic exp_in, input int eox, input int eoy);
        pixelX = 11'(px);
        pixelY = 11'(py);
        #1;
        chk({tag, ".inside"}, InsideRectangle, exp_in);
        chk({tag, ".offX"}, offsetX, eox);
        chk({tag, ".offY"}, offsetY, eoy);
    endtask

    initial begin
        int land_frame;
        int y_now;
        int y_prev;
        int n;
        int r;

        model_reset();
        reset  = 1'b1;
        pixelX = 11'(37);
        pixelY = 11'(5);
        #3;
        chk("rst.visible", visible, 0);
        chk("rst.active", active, 0);
        chk("rst.taken", presentTaken, 0);
        chk("rst.inside", InsideRectangle, 0);
        chk("rst.offX", offsetX, 37);
        chk("rst.offY", offsetY, 5);
        @(negedge clk);
        reset = 1'b0;

        // Drop from (100,400) to the floor.
        step(1'b0, 1'b1, 100, 400, 1'b0, "spawn1");
        land_frame = 0;
        for (int k = 1; k <= 15; k++) begin
            frame("fall1");
            pixelX = 11'(100);
            pixelY = 11'(414);
            #1;
            if (land_frame == 0 && offsetY == 11'(0)) land_frame = k;
        end
        chk("fall1.land_frame", land_frame, 15);
        probe_y(y_now);
        chk("fall1.rest_y", y_now, 414);

        pix("sweep.tl", 100, 414, 1'b1, 0, 0);
        pix("sweep.br", 125, 439, 1'b1, 25, 25);
        pix("sweep.right", 126, 414, 1'b0, 26, 0);
        pix("sweep.left", 99, 420, 1'b0, 2047, 6);
        pix("sweep.below", 110, 440, 1'b0, 10, 26);

        for (int k = 0; k < LANDF + BLINKF; k++) frame("expire1");
        chk("expire1.active", active, 0);
        pix("idle.tl", 100, 414, 1'b0, 0, 0);
        pix("idle.mid", 112, 427, 1'b0, 12, 13);
        pix("idle.org", 0, 0, 1'b0, 2048 - 100, 2048 - 414);

        // Long fall from the top: speed saturates, then 6 px per frame.
        step(1'b0, 1'b1, 50, 0, 1'b0, "spawn2");
        y_prev = 0;
        n = 0;
        for (int k = 1; k <= 150; k++) begin
            frame("fall2");
            probe_y(y_now);
            n = k;
            if (k >= 49 && m_phase == P_FALL)
                chk("fall2.step6", y_now - y_prev, 6);
            y_prev = y_now;
            if (m_phase != P_FALL) break;
        end
        chk("fall2.land_frame", n, 93);
        chk("fall2.rest_y", y_now, 414);
        for (int k = 0; k < LANDF + BLINKF; k++) frame("expire2");
        chk("expire2.active", active, 0);

        // Collection held for three cycles, with a competing spawn.
        step(1'b0, 1'b1, 200, 10, 1'b0, "spawn3");
        for (int k = 0; k < 3; k++) frame("fall3");
        probe_y(y_prev);
        n_pulses = 0;
        step(1'b1, 1'b1, 300, 50, 1'b1, "col.a");
        step(1'b0, 1'b0, 0, 0, 1'b1, "col.b");
        step(1'b0, 1'b0, 0, 0, 1'b1, "col.c");
        step(1'b0, 1'b0, 0, 0, 1'b0, "col.d");
        chk("col.pulses", n_pulses, 1);
        probe_y(y_now);
        chk("col.y_held", y_now, y_prev);

        // Spawn and collect together while idle: spawn wins.
        step(1'b0, 1'b1, 120, 30, 1'b1, "spcol");
        chk("spcol.active", active, 1);
        frame("spcol.f");
        step(1'b0, 1'b0, 0, 0, 1'b1, "spcol.clr");
        step(1'b0, 1'b0, 0, 0, 1'b0, "spcol.q");

        // Randomized traffic.
        for (int it = 0; it < 6; it++) begin
            for (int s = 0; s < 200; s++) begin
                r = int'($urandom_range(0, 99));
                step(r < 40, r >= 95 && r < 99,
                     int'($urandom_range(0, 600)),
                     int'($urandom_range(0, 600)),
                     r == 99, "rand");
            end
        end

        // Asynchronous reset in the middle of a fall.
        step(1'b0, 1'b0, 0, 0, 1'b1, "pre.clr");
        step(1'b0, 1'b0, 0, 0, 1'b0, "pre.q");
        step(1'b0, 1'b1, 100, 100, 1'b0, "spawn4");
        for (int k = 0; k < 5; k++) frame("fall4");
        pixelX = 11'(m_x + 3);
        pixelY = 11'(m_y64 / 64 + 3);
        #1;
        chk("arst.pre_inside", InsideRectangle, 1);
        reset = 1'b1;
        #1;
        chk("arst.visible", visible, 0);
        chk("arst.active", active, 0);
        chk("arst.inside", InsideRectangle, 0);
        chk("arst.taken", presentTaken, 0);
        chk("arst.offX", offsetX, 103);
        chk("arst.offY", offsetY, (m_y64 / 64) + 3);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        step(1'b1, 1'b0, 0, 0, 1'b0, "post");
        step(1'b0, 1'b0, 0, 0, 1'b1, "post.col");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
